data_memory_reader: RTL

Sequential read-out engine for the 16-bit data memory. On a start pulse it reads `count` words, beginning at a base address and stepping by a fixed address stride. It delivers the words in order on a valid/ready output stream. It is the read-side counterpart of the memory write path: it drives the memory address port, never asserts write-enable, and feeds results (e.g. processed image data) to a downstream consumer.

---
 rtl/data_memory_reader.sv | 125 ++++++++++++
 1 files changed

// File: rtl/data_memory_reader.sv
// Sequential read-out engine: streams `count` words from the data memory,
// starting at base_addr and stepping by ADDR_STEP, onto a valid/ready port.
module data_memory_reader #(
   parameter int unsigned AW        = 16,
   parameter int unsigned DW        = 16,
   parameter int unsigned ADDR_STEP = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   input  logic [15:0]   count,
   output logic          mem_we,
   output logic [AW-1:0] mem_a,
   input  logic [DW-1:0] mem_rd,
   output logic          m_valid,
   output logic [DW-1:0] m_data,
   output logic          m_last,
   input  logic          m_ready,
   output logic          busy,
   output logic          done,
   output logic [31:0]   words_sent
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FINISH
   } state_t;

   state_t        state;
   state_t        state_nx;

   logic [15:0]   remaining;
   logic          pend;
   logic          pend_last;

   logic [DW-1:0] fifo_data [2];
   logic          fifo_last [2];
   logic          rd_ptr;
   logic          wr_ptr;
   logic [1:0]    fifo_count;

   logic          pop;
   logic          start_go;
   logic          issue;
   logic [2:0]    occ;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      pop      = (fifo_count != 2'd0) && m_ready;
      start_go = (state == IDLE) && start && (count != 16'd0);
      // occupancy seen by the next read: buffered, minus leaving, plus in flight
      occ      = {1'b0, fifo_count} - {2'b00, pop} + {2'b00, pend};
      issue    = (state == RUN) && (remaining != 16'd0) && (occ < 3'd2);
      case (state)
         IDLE:    if (start) state_nx = (count != 16'd0) ? RUN : FINISH;
         RUN:     if (pop && fifo_last[rd_ptr]) state_nx = FINISH;
         FINISH:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_a      <= '0;
         remaining  <= '0;
         pend       <= 1'b0;
         pend_last  <= 1'b0;
         rd_ptr     <= 1'b0;
         wr_ptr     <= 1'b0;
         fifo_count <= '0;
         words_sent <= '0;
         for (int unsigned i = 0; i < 2; i++) begin
            fifo_data[i] <= '0;
            fifo_last[i] <= 1'b0;
         end
      end else begin
         if (start_go) begin
            mem_a     <= base_addr;
            remaining <= count - 16'd1;
            pend      <= 1'b1;
            pend_last <= (count == 16'd1);
         end else if (issue) begin
            mem_a     <= mem_a + AW'(ADDR_STEP);
            remaining <= remaining - 16'd1;
            pend      <= 1'b1;
            pend_last <= (remaining == 16'd1);
         end else begin
            pend      <= 1'b0;
            pend_last <= 1'b0;
         end

         if (pend) begin
            fifo_data[wr_ptr] <= mem_rd;
            fifo_last[wr_ptr] <= pend_last;
            wr_ptr            <= ~wr_ptr;
         end

         if (pop) begin
            rd_ptr     <= ~rd_ptr;
            words_sent <= words_sent + 32'd1;
         end

         case ({pend, pop})
            2'b10:   fifo_count <= fifo_count + 2'd1;
            2'b01:   fifo_count <= fifo_count - 2'd1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   assign mem_we  = 1'b0;
   assign m_valid = (fifo_count != 2'd0);
   assign m_data  = fifo_data[rd_ptr];
   assign m_last  = m_valid && fifo_last[rd_ptr];
   assign busy    = (state == RUN);
   assign done    = (state == FINISH);

endmodule
